bus_arbiter: RTL and testbench

//  Shares one Wishbone-classic memory port between the IF stage (instruction fetch) and the MEM

---
 rtl/bus_arbiter_pkg.sv | 28 ++
 rtl/bus_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared state encodings and constants for the IF/MEM bus arbiter
package bus_arbiter_pkg;

    localparam int BUS_ARB_STATE_W = 2;

    typedef logic [BUS_ARB_STATE_W-1:0] arb_state_t;

    localparam arb_state_t ARB_IDLE   = 2'd0;
    localparam arb_state_t ARB_BUSY_I = 2'd1;
    localparam arb_state_t ARB_BUSY_D = 2'd2;
    localparam arb_state_t ARB_DROP_I = 2'd3;

    localparam int ARB_TIMEOUT_DEFAULT = 255;

    // Instruction returned to IF when its fetch is aborted by the timeout.
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    // Round-robin bit records which side was served last; reset value favours MEM first.
    localparam logic RR_IF = 1'b0;
    localparam logic RR_D  = 1'b1;

    localparam logic [3:0] SEL_WORD = 4'b1111;

    function automatic logic rr_flip(input logic rr);
        return (rr == RR_IF) ? RR_D : RR_IF;
    endfunction

endpackage

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - shares one Wishbone-classic port between instruction fetch and load/store
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = ARB_TIMEOUT_DEFAULT,
    parameter int DATA_PRIO = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_stallreq_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [3:0]        d_sel_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ack_o,
    output logic              d_err_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_stallreq_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [3:0]        s_sel_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_wdata_o,
    input  logic              s_ack_i,
    input  logic [DATA_W-1:0] s_rdata_i
);

    localparam int              CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit              TIMEOUT_EN = (TIMEOUT != 0);
    localparam bit              PRIO_D     = (DATA_PRIO != 0);

    arb_state_t        state_q, state_d;
    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rr_q, rr_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              d_err_q, d_err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic timed_out;
    logic pulse_cycle;
    logic if_want;
    logic d_wins;

    // The cycle that hits the limit without an ack is the last one cyc stays high.
    assign timed_out   = TIMEOUT_EN && !s_ack_i && (cnt_q == CNT_LAST);
    assign pulse_cycle = if_ack_q || d_ack_q || d_err_q;
    assign if_want     = if_req_i && !flush_i;
    assign d_wins      = d_req_i && (PRIO_D || (rr_q == RR_IF) || !if_want);

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;
        d_err_d    = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            ARB_IDLE: begin
                // Requesters still hold req during their ack pulse, so no grant then.
                if (!pulse_cycle) begin
                    if (d_wins) begin
                        state_d = ARB_BUSY_D;
                        cyc_d   = 1'b1;
                        we_d    = d_we_i;
                        sel_d   = d_sel_i;
                        addr_d  = d_addr_i;
                        wdata_d = d_wdata_i;
                        cnt_d   = '0;
                    end else if (if_want) begin
                        state_d = ARB_BUSY_I;
                        cyc_d   = 1'b1;
                        we_d    = 1'b0;
                        sel_d   = SEL_WORD;
                        addr_d  = if_addr_i;
                        wdata_d = '0;
                        cnt_d   = '0;
                    end
                end
            end

            ARB_BUSY_I: begin
                if (s_ack_i) begin
                    state_d = ARB_IDLE;
                    cyc_d   = 1'b0;
                    rr_d    = rr_flip(rr_q);
                    if (!flush_i) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = s_rdata_i;
                    end
                end else if (flush_i) begin
                    state_d = ARB_DROP_I;
                    cnt_d   = '0;
                end else if (timed_out) begin
                    state_d    = ARB_IDLE;
                    cyc_d      = 1'b0;
                    rr_d       = rr_flip(rr_q);
                    if_ack_d   = 1'b1;
                    if_rdata_d = DATA_W'(NOP_INST);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ARB_BUSY_D: begin
                if (s_ack_i) begin
                    state_d   = ARB_IDLE;
                    cyc_d     = 1'b0;
                    rr_d      = rr_flip(rr_q);
                    d_ack_d   = 1'b1;
                    d_rdata_d = s_rdata_i;
                end else if (timed_out) begin
                    state_d = ARB_IDLE;
                    cyc_d   = 1'b0;
                    rr_d    = rr_flip(rr_q);
                    d_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ARB_DROP_I: begin
                if (s_ack_i || timed_out) begin
                    state_d = ARB_IDLE;
                    cyc_d   = 1'b0;
                    rr_d    = rr_flip(rr_q);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ARB_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            rr_q       <= RR_IF;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            d_err_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            d_err_q    <= d_err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign s_cyc_o    = cyc_q;
    assign s_stb_o    = cyc_q;
    assign s_we_o     = we_q;
    assign s_sel_o    = sel_q;
    assign s_addr_o   = addr_q;
    assign s_wdata_o  = wdata_q;
    assign if_ack_o   = if_ack_q;
    assign if_rdata_o = if_rdata_q;
    assign d_ack_o    = d_ack_q;
    assign d_err_o    = d_err_q;
    assign d_rdata_o  = d_rdata_q;

    // Gated by rst so every output reads 0 while reset is held.
    assign if_stallreq_o = !rst && if_req_i && !if_ack_q && !flush_i;
    assign d_stallreq_o  = !rst && d_req_i && !d_ack_q && !d_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;

    logic clk, rst;

    // Instance A: DATA_PRIO=1, TIMEOUT=4
    logic        a_flush, a_if_req, a_if_ack, a_if_stall;
    logic [31:0] a_if_addr, a_if_rdata;
    logic        a_d_req, a_d_we, a_d_ack, a_d_err, a_d_stall;
    logic [3:0]  a_d_sel, a_s_sel;
    logic [31:0] a_d_addr, a_d_wdata, a_d_rdata;
    logic        a_s_cyc, a_s_stb, a_s_we, a_s_ack;
    logic [31:0] a_s_addr, a_s_wdata, a_s_rdata;

    // Instance B: DATA_PRIO=0
    logic        b_flush, b_if_req, b_if_ack, b_if_stall;
    logic [31:0] b_if_addr, b_if_rdata;
    logic        b_d_req, b_d_we, b_d_ack, b_d_err, b_d_stall;
    logic [3:0]  b_d_sel, b_s_sel;
    logic [31:0] b_d_addr, b_d_wdata, b_d_rdata;
    logic        b_s_cyc, b_s_stb, b_s_we, b_s_ack;
    logic [31:0] b_s_addr, b_s_wdata, b_s_rdata;

    bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .DATA_PRIO(1)) u_dut_a (
        .clk(clk), .rst(rst), .flush_i(a_flush),
        .if_req_i(a_if_req), .if_addr_i(a_if_addr), .if_ack_o(a_if_ack),
        .if_rdata_o(a_if_rdata), .if_stallreq_o(a_if_stall),
        .d_req_i(a_d_req), .d_we_i(a_d_we), .d_sel_i(a_d_sel), .d_addr_i(a_d_addr),
        .d_wdata_i(a_d_wdata), .d_ack_o(a_d_ack), .d_err_o(a_d_err),
        .d_rdata_o(a_d_rdata), .d_stallreq_o(a_d_stall),
        .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb), .s_we_o(a_s_we), .s_sel_o(a_s_sel),
        .s_addr_o(a_s_addr), .s_wdata_o(a_s_wdata), .s_ack_i(a_s_ack), .s_rdata_i(a_s_rdata)
    );

    bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255), .DATA_PRIO(0)) u_dut_b (
        .clk(clk), .rst(rst), .flush_i(b_flush),
        .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_ack_o(b_if_ack),
        .if_rdata_o(b_if_rdata), .if_stallreq_o(b_if_stall),
        .d_req_i(b_d_req), .d_we_i(b_d_we), .d_sel_i(b_d_sel), .d_addr_i(b_d_addr),
        .d_wdata_i(b_d_wdata), .d_ack_o(b_d_ack), .d_err_o(b_d_err),
        .d_rdata_o(b_d_rdata), .d_stallreq_o(b_d_stall),
        .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_we_o(b_s_we), .s_sel_o(b_s_sel),
        .s_addr_o(b_s_addr), .s_wdata_o(b_s_wdata), .s_ack_i(b_s_ack), .s_rdata_i(b_s_rdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave models: ack lat+1 negedges after cyc rises, log each completed bus beat.
    bit          a_slv_en = 1'b1;
    int          a_lat = 2;
    logic [31:0] a_slv_rdata = '0;
    logic [31:0] a_log_addr[$];
    logic [31:0] a_log_wdata[$];
    logic [3:0]  a_log_sel[$];
    logic        a_log_we[$];
    int          b_lat = 0;
    logic [31:0] b_log_addr[$];

    initial begin
        int wt;
        wt = 0;
        a_s_ack = 1'b0;
        a_s_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst || a_s_ack || !a_s_cyc || !a_slv_en) begin
                a_s_ack = 1'b0;
                wt = 0;
            end else if (wt >= a_lat) begin
                a_s_ack = 1'b1;
                a_s_rdata = a_slv_rdata;
                a_log_addr.push_back(a_s_addr);
                a_log_wdata.push_back(a_s_wdata);
                a_log_sel.push_back(a_s_sel);
                a_log_we.push_back(a_s_we);
            end else begin
                wt++;
            end
        end
    end

    initial begin
        int wt;
        wt = 0;
        b_s_ack = 1'b0;
        b_s_rdata = 32'h0000_00B0;
        forever begin
            @(negedge clk);
            if (rst || b_s_ack || !b_s_cyc) begin
                b_s_ack = 1'b0;
                wt = 0;
            end else if (wt >= b_lat) begin
                b_s_ack = 1'b1;
                b_log_addr.push_back(b_s_addr);
            end else begin
                wt++;
            end
        end
    end

    int a_n_if_ack = 0, a_n_d_ack = 0, a_n_d_err = 0;
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (a_if_ack) a_n_if_ack++;
            if (a_d_ack)  a_n_d_ack++;
            if (a_d_err)  a_n_d_err++;
        end
    end

    // Runs instance A until both requesters have seen their completion, recording the order.
    string order;
    int    stall_bad;
    task automatic run_a(input int max_cyc);
        int k;
        order = "";
        stall_bad = 0;
        for (k = 0; k < max_cyc && (a_if_req || a_d_req); k++) begin
            @(negedge clk);
            if (a_if_req && !a_if_ack && !a_flush && a_if_stall !== 1'b1) stall_bad++;
            if (a_d_req && !a_d_ack && !a_d_err && a_d_stall !== 1'b1) stall_bad++;
            if (a_if_req && a_if_ack) begin
                if (a_if_stall !== 1'b0) stall_bad++;
                a_if_req = 1'b0;
                order = {order, "I"};
            end
            if (a_d_req && (a_d_ack || a_d_err)) begin
                if (a_d_stall !== 1'b0) stall_bad++;
                a_d_req = 1'b0;
                order = {order, "D"};
            end
        end
        check_eq("run_a_bound", 64'(a_if_req || a_d_req), 64'd0);
    endtask

    task automatic check_reset_a(input string tag);
        check_eq({tag, "_cyc_stb_we"}, {61'd0, a_s_cyc, a_s_stb, a_s_we}, 64'd0);
        check_eq({tag, "_sel_addr"}, {28'd0, a_s_sel, a_s_addr}, 64'd0);
        check_eq({tag, "_wdata"}, 64'(a_s_wdata), 64'd0);
        check_eq({tag, "_pulses_stalls"}, {59'd0, a_if_ack, a_d_ack, a_d_err, a_if_stall, a_d_stall}, 64'd0);
        check_eq({tag, "_rdata"}, {a_if_rdata, a_d_rdata}, 64'd0);
    endtask

    initial begin
        int base, n0, cyc_cnt;
        rst = 1'b1;
        a_flush = 0; a_if_req = 0; a_if_addr = '0; a_d_req = 0; a_d_we = 0;
        a_d_sel = '0; a_d_addr = '0; a_d_wdata = '0;
        b_flush = 0; b_if_req = 0; b_if_addr = '0; b_d_req = 0; b_d_we = 0;
        b_d_sel = '0; b_d_addr = '0; b_d_wdata = '0;
        #2;
        check_reset_a("reset");
        check_eq("reset_b", {b_s_cyc, b_if_ack, b_d_ack, b_d_err, b_if_rdata, b_d_rdata}, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: lone IF read
        a_lat = 2;
        a_slv_rdata = 32'h3402_0020;
        a_if_addr = 32'h0000_0100;
        a_if_req = 1'b1;
        #1 check_eq("t1_stall_req_cycle", 64'(a_if_stall), 64'd1);
        run_a(30);
        check_eq("t1_stall_window", 64'(stall_bad), 64'd0);
        check_eq("t1_rdata", 64'(a_if_rdata), 64'h3402_0020);
        repeat (3) @(negedge clk);
        check_eq("t1_ack_count", 64'(a_n_if_ack), 64'd1);
        check_eq("t1_bus", {a_log_addr[0], 27'd0, a_log_we[0], a_log_sel[0]}, {32'h100, 27'd0, 1'b0, 4'hF});
        check_eq("t1_rdata_hold", 64'(a_if_rdata), 64'h3402_0020);

        // 2: simultaneous IF + store, MEM first
        a_slv_rdata = 32'h1111_2222;
        a_if_addr = 32'h0000_0200;
        a_d_we = 1'b1; a_d_sel = 4'hF; a_d_addr = 32'h8000_0010; a_d_wdata = 32'hDEAD_BEEF;
        a_if_req = 1'b1; a_d_req = 1'b1;
        run_a(40);
        check_eq("t2_order", 64'(order == "DI"), 64'd1);
        check_eq("t2_stalls", 64'(stall_bad), 64'd0);
        check_eq("t2_store_bus", {a_log_addr[1], a_log_wdata[1]}, {32'h8000_0010, 32'hDEAD_BEEF});
        check_eq("t2_store_we_sel", {59'd0, a_log_we[1], a_log_sel[1]}, {59'd0, 1'b1, 4'hF});
        check_eq("t2_fetch_bus", {a_log_addr[2], 27'd0, a_log_we[2], a_log_sel[2]}, {32'h200, 27'd0, 1'b0, 4'hF});
        check_eq("t2_if_rdata", 64'(a_if_rdata), 64'h1111_2222);
        repeat (2) @(negedge clk);

        // 4: flush one cycle after the IF grant
        base = a_log_addr.size();
        n0 = a_n_if_ack;
        a_slv_rdata = 32'h5555_AAAA;
        a_if_addr = 32'h0000_0300;
        a_if_req = 1'b1;
        @(negedge clk);
        check_eq("t4_granted", 64'(a_s_cyc), 64'd1);
        a_flush = 1'b1;
        a_if_req = 1'b0;
        #1 check_eq("t4_stall_flush", 64'(a_if_stall), 64'd0);
        @(negedge clk);
        a_flush = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("t4_no_ack", 64'(a_n_if_ack - n0), 64'd0);
        check_eq("t4_rdata_kept", 64'(a_if_rdata), 64'h1111_2222);
        check_eq("t4_bus_completed", 64'(a_log_addr.size() - base), 64'd1);
        a_slv_rdata = 32'h7777_0001;
        a_if_addr = 32'h0000_0304;
        a_if_req = 1'b1;
        run_a(30);
        check_eq("t4_next_fetch", {a_if_rdata, a_log_addr[base + 1]}, {32'h7777_0001, 32'h304});

        // load with a narrow byte select
        a_lat = 1;
        a_slv_rdata = 32'hCAFE_F00D;
        a_d_we = 1'b0; a_d_sel = 4'b0011; a_d_addr = 32'h0000_0044;
        a_d_req = 1'b1;
        run_a(30);
        check_eq("load_rdata", 64'(a_d_rdata), 64'hCAFE_F00D);
        check_eq("load_bus", {27'd0, a_log_we[a_log_we.size() - 1], a_log_sel[a_log_sel.size() - 1]}, {27'd0, 1'b0, 4'b0011});
        repeat (2) @(negedge clk);

        // 5: timeout on a load
        a_slv_en = 1'b0;
        n0 = a_n_d_ack;
        a_d_addr = 32'h0000_0040;
        a_d_req = 1'b1;
        cyc_cnt = 0;
        for (int k = 0; k < 20 && a_d_req; k++) begin
            @(negedge clk);
            if (a_s_cyc) cyc_cnt++;
            if (a_d_err) begin
                check_eq("t5_stall_clear", 64'(a_d_stall), 64'd0);
                a_d_req = 1'b0;
            end
        end
        check_eq("t5_err_seen", 64'(a_d_req), 64'd0);
        check_eq("t5_cyc_cycles", 64'(cyc_cnt), 64'd4);
        repeat (3) @(negedge clk);
        check_eq("t5_err_count", 64'(a_n_d_err), 64'd1);
        check_eq("t5_no_ack", 64'(a_n_d_ack - n0), 64'd0);
        check_eq("t5_rdata_kept", 64'(a_d_rdata), 64'hCAFE_F00D);

        // 6: reset during a MEM access
        a_d_addr = 32'h0000_0048;
        a_d_req = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("t6_busy", 64'(a_s_cyc), 64'd1);
        rst = 1'b1;
        #1 check_reset_a("t6_rst");
        @(negedge clk);
        a_d_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        a_slv_en = 1'b1;
        a_lat = 1;
        a_slv_rdata = 32'h0BAD_CAFE;
        n0 = a_n_d_ack;
        @(negedge clk);
        a_d_req = 1'b1;
        run_a(30);
        check_eq("t6_fresh_rdata", 64'(a_d_rdata), 64'h0BAD_CAFE);
        check_eq("t6_fresh_ack", 64'(a_n_d_ack - n0), 64'd1);

        // 3: round-robin on instance B with both requests held
        b_if_addr = 32'h0000_1000;
        b_d_addr = 32'h0000_2000;
        b_d_sel = 4'hF;
        b_if_req = 1'b1; b_d_req = 1'b1;
        for (int k = 0; k < 60 && b_log_addr.size() < 4; k++) @(negedge clk);
        b_if_req = 1'b0; b_d_req = 1'b0;
        check_eq("t3_four_grants", 64'(b_log_addr.size() >= 4), 64'd1);
        if (b_log_addr.size() >= 4) begin
            check_eq("t3_seq01", {b_log_addr[0], b_log_addr[1]}, {32'h2000, 32'h1000});
            check_eq("t3_seq23", {b_log_addr[2], b_log_addr[3]}, {32'h2000, 32'h1000});
        end
        repeat (5) @(negedge clk);
        check_eq("t3_idle", 64'(b_s_cyc), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=stuck expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
